fe_req_responder: RTL



---
 rtl/fe_req_responder_if.sv | 19 +
 rtl/fe_req_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fe_req_responder_if.sv
// Avalon-MM slave bundle for fe_req_responder: word address, 1-cycle strobes,
// fixed read latency of one clock, no waitrequest.
interface fe_req_responder_if;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;

  modport master (
    output s_address, s_read, s_write, s_writedata,
    input  s_readdata
  );

  modport slave (
    input  s_address, s_read, s_write, s_writedata,
    output s_readdata
  );
endinterface

// File: rtl/fe_req_responder.sv
// Front-end request responder: sticky rising-edge pending bits, mask, level IRQ,
// and a pop register. Optional 2-flop input synchroniser under FE_REQ_SYNC_EN.

// One request line: edge detector, sticky pending bit and its mask bit.
module fe_req_cell (
  input  logic clk,
  input  logic reset,
  input  logic req_s,
  input  logic mask_we,
  input  logic mask_wd,
  input  logic clr,
  output logic pend,
  output logic mask
);
  logic req_q;

  // A rise wins over a same-edge clear so no request is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= 1'b0;
      pend  <= 1'b0;
      mask  <= 1'b0;
    end else begin
      req_q <= req_s;
      pend  <= (req_s & ~req_q) | (pend & ~clr);
      if (mask_we) mask <= mask_wd;
    end
  end
endmodule

module fe_req_responder #(
  parameter int NREQ = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         fe_req,
  fe_req_responder_if.slave   av,
  output logic                irq
);
  localparam int          STAGES = 1;
  localparam logic [31:0] IMPL   = 32'((64'd1 << NREQ) - 64'd1);

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_req_t;

  bus_req_t    breq;
  logic [31:0] req_s;
  logic [31:0] pend;
  logic [31:0] mask;
  logic [31:0] en;
  logic [31:0] clr;
  logic [31:0] raw;
  logic [31:0] rd_mux;
  logic [31:0] rdata_q;
  logic [4:0]  nxt_idx;
  logic        nxt_vld;
  logic        wr_pend;
  logic        wr_mask;
  logic        pop;
  logic [STAGES:0] vld_pipe;

  assign breq = '{rd: av.s_read, wr: av.s_write, addr: av.s_address,
                  wdata: av.s_writedata};

`ifdef FE_REQ_SYNC_EN
  logic [1:0][31:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], fe_req};
  end

  assign req_s = sync_q[1];
`else
  assign req_s = fe_req;
`endif

  assign wr_pend = breq.wr & (breq.addr == 2'd0);
  assign wr_mask = breq.wr & (breq.addr == 2'd1);
  assign en      = pend & mask;
  assign raw     = req_s & IMPL;

  // Lowest-numbered enabled request wins the pop.
  always_comb begin
    nxt_vld = 1'b0;
    nxt_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (en[i]) begin
        nxt_vld = 1'b1;
        nxt_idx = 5'(i);
      end
    end
  end

  assign pop = breq.rd & (breq.addr == 2'd3) & nxt_vld;
  assign clr = ({32{wr_pend}} & breq.wdata) | (pop ? (32'd1 << nxt_idx) : 32'd0);

  for (genvar n = 0; n < 32; n++) begin : g_lane
    if (n < NREQ) begin : g_on
      fe_req_cell u_cell (
        .clk     (clk),
        .reset   (reset),
        .req_s   (req_s[n]),
        .mask_we (wr_mask),
        .mask_wd (breq.wdata[n]),
        .clr     (clr[n]),
        .pend    (pend[n]),
        .mask    (mask[n])
      );
    end else begin : g_off
      assign pend[n] = 1'b0;
      assign mask[n] = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (breq.addr)
      2'd0: rd_mux = pend;
      2'd1: rd_mux = mask;
      2'd2: rd_mux = raw;
      2'd3: rd_mux = {nxt_vld, 26'b0, nxt_idx};
      default: rd_mux = '0;
    endcase
  end

  // Read data is taken from pre-update state, so a same-cycle write is not seen.
  assign vld_pipe[0] = breq.rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[STAGES:1] <= '0;
      rdata_q            <= '0;
      irq                <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (breq.rd) rdata_q <= rd_mux;
      irq <= |en;
    end
  end

  assign av.s_readdata = vld_pipe[STAGES] ? rdata_q : 32'd0;
endmodule
